// File: rtl/park_encrypt.sv
// Parking-lot entry encryptor. It allocates the lowest free slot on entry,
// issues token = slot ^ pattern over a valid/ack handshake, and abandons the
// token (releasing its slot) if no ack arrives within ACK_TIMEOUT cycles.
module park_encrypt #(
    parameter int unsigned NUM_SLOTS   = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic [2:0] pattern,
    input  logic       tok_ack,
    input  logic       free_valid,
    input  logic [2:0] free_number,
    output logic [2:0] token,
    output logic       token_valid,
    output logic       full,
    output logic [3:0] count,
    output logic       reject,
    output logic       timeout
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAlloc, StIssue} state_e;

    state_e                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   occ_q, occ_d;
    logic [2:0]             pat_q, pat_d;
    logic [2:0]             slot_q, slot_d;
    logic [2:0]             token_q, token_d;
    logic                   valid_q, valid_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        cnt_inc;
    logic [3:0]             count_q, count_d;
    logic                   full_q, full_d;
    logic                   reject_q, reject_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             free_slot;

    // Lowest-numbered free slot, taken from the registered map.
    always_comb begin
        free_slot = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_slot = 3'(i);
        end
    end

    // Next-state logic: free path first, then the FSM may set or clear bits.
    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        pat_d     = pat_q;
        slot_d    = slot_q;
        token_d   = token_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        cnt_inc   = cnt_q + CntW'(1);

        if (free_valid && (int'(free_number) < int'(NUM_SLOTS))) begin
            occ_d[free_number] = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (enter) begin
                    if (full_q) begin
                        reject_d = 1'b1;
                    end else begin
                        pat_d   = pattern;
                        state_d = StAlloc;
                    end
                end
            end
            StAlloc: begin
                occ_d[free_slot] = 1'b1;
                slot_d           = free_slot;
                token_d          = free_slot ^ pat_q;
                valid_d          = 1'b1;
                cnt_d            = '0;
                state_d          = StIssue;
            end
            StIssue: begin
                if (tok_ack) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (cnt_inc == CntW'(ACK_TIMEOUT)) begin
                    occ_d[slot_q] = 1'b0;
                    timeout_d     = 1'b1;
                    valid_d       = 1'b0;
                    cnt_d         = cnt_inc;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        // Occupancy summary tracks the map being written this edge.
        count_d = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            count_d = count_d + 4'(occ_d[i]);
        end
        full_d = &occ_d;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            occ_q     <= '0;
            pat_q     <= '0;
            slot_q    <= '0;
            token_q   <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            pat_q     <= pat_d;
            slot_q    <= slot_d;
            token_q   <= token_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            full_q    <= full_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    assign token       = token_q;
    assign token_valid = valid_q;
    assign full        = full_q;
    assign count       = count_q;
    assign reject      = reject_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_park_encrypt.sv
// Self-checking bench for park_encrypt: directed scenarios then randomized
// entries/frees against a slot-set model of the lot.
module tb_park_encrypt;

    localparam int ACK_T = 15;

    logic       clk;
    logic       rst_n;
    logic       enter;
    logic [2:0] pattern;
    logic       tok_ack;
    logic       free_valid;
    logic [2:0] free_number;
    logic [2:0] token;
    logic       token_valid;
    logic       full;
    logic [3:0] count;
    logic       reject;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Model: set of occupied slots.
    bit [7:0] m_occ;

    park_encrypt #(.NUM_SLOTS(8), .ACK_TIMEOUT(ACK_T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enter       (enter),
        .pattern     (pattern),
        .tok_ack     (tok_ack),
        .free_valid  (free_valid),
        .free_number (free_number),
        .token       (token),
        .token_valid (token_valid),
        .full        (full),
        .count       (count),
        .reject      (reject),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 8; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    task automatic check_summary(input string tag);
        check({tag, "_count"}, count, 8'($countones(m_occ)));
        check({tag, "_full"}, full, (m_occ == 8'hFF) ? 8'd1 : 8'd0);
    endtask

    // One entry; ack_delay = number of non-ack ISSUE cycles before the ack
    // (>= ACK_T means never acked). Optional free on the allocation edge.
    task automatic do_entry(input logic [2:0] pat, input int ack_delay,
                            input bit do_free, input logic [2:0] fnum);
        int         slot;
        logic [2:0] exp_tok;
        if (m_occ == 8'hFF) begin
            enter = 1'b1; pattern = pat;
            tick();
            check("reject_pulse", reject, 1);
            check("reject_novalid", token_valid, 0);
            enter = 1'b0;
            tick();
            check("reject_end", reject, 0);
            check("reject_novalid2", token_valid, 0);
            check_summary("reject");
            return;
        end
        slot    = lowest_free();
        exp_tok = 3'(slot) ^ pat;
        enter = 1'b1; pattern = pat;
        tick();
        check("alloc_novalid", token_valid, 0);
        enter   = 1'b0;
        pattern = 3'($urandom);
        if (do_free) begin
            free_valid = 1'b1; free_number = fnum;
        end
        tick();
        free_valid = 1'b0;
        m_occ[slot] = 1'b1;
        if (do_free) m_occ[fnum] = 1'b0;
        check("issue_valid", token_valid, 1);
        check("issue_token", token, exp_tok);
        check_summary("issue");
        for (int k = 0; k < ACK_T; k++) begin
            if (k == ack_delay) begin
                tok_ack = 1'b1;
                tick();
                tok_ack = 1'b0;
                check("ack_valid", token_valid, 0);
                check("ack_notimeout", timeout, 0);
                check_summary("ack");
                break;
            end
            tick();
            if (k + 1 == ACK_T) begin
                m_occ[slot] = 1'b0;
                check("to_pulse", timeout, 1);
                check("to_valid", token_valid, 0);
                check_summary("to");
                tick();
                check("to_end", timeout, 0);
            end else begin
                check("hold_valid", token_valid, 1);
                check("hold_token", token, exp_tok);
                check("hold_notimeout", timeout, 0);
            end
        end
    endtask

    task automatic do_free(input logic [2:0] n);
        free_valid = 1'b1; free_number = n;
        tick();
        free_valid = 1'b0;
        m_occ[n] = 1'b0;
        check_summary("free");
    endtask

    initial begin
        rst_n = 1'b0; enter = 1'b0; pattern = '0; tok_ack = 1'b0;
        free_valid = 1'b0; free_number = '0; m_occ = '0;
        tick(); tick();
        check("rst_valid", token_valid, 0);
        check("rst_token", token, 0);
        check("rst_reject", reject, 0);
        check("rst_timeout", timeout, 0);
        check_summary("rst");
        rst_n = 1'b1;
        tick();

        // First entry: slot 0, token 7; second: slot 1, token 0.
        do_entry(3'b111, 0, 1'b0, 3'd0);
        do_entry(3'b001, 2, 1'b0, 3'd0);
        // Slot 0 released and reused.
        do_free(3'd0);
        do_entry(3'b101, 1, 1'b0, 3'd0);

        // Fill the lot, then a refused entry.
        while (m_occ != 8'hFF) do_entry(3'($urandom), int'($urandom_range(0, 3)), 1'b0, 3'd0);
        check("full_flag", full, 1);
        check("full_count", count, 8);
        do_entry(3'b010, 0, 1'b0, 3'd0);

        // Double free of slot 5 is a no-op, then a timed-out entry.
        do_free(3'd5);
        do_free(3'd5);
        do_entry(3'b011, ACK_T, 1'b0, 3'd0);
        // Ack on the expiry edge wins.
        do_entry(3'b110, ACK_T - 1, 1'b0, 3'd0);

        // Leave slots 0..2 occupied; free slot 2 on the edge slot 3 is allocated.
        for (int i = 3; i < 8; i++) do_free(3'(i));
        do_entry(3'b100, 0, 1'b1, 3'd2);
        do_free(3'd5);

        // Reset in the middle of a handshake.
        enter = 1'b1; pattern = 3'b011;
        tick();
        enter = 1'b0;
        tick();
        check("pre_rst_valid", token_valid, 1);
        rst_n = 1'b0;
        tick();
        m_occ = '0;
        check("mid_rst_valid", token_valid, 0);
        check("mid_rst_token", token, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_reject", reject, 0);
        check_summary("mid_rst");
        rst_n = 1'b1;
        for (int i = 0; i < ACK_T + 2; i++) begin
            tick();
            check("post_rst_timeout", timeout, 0);
            check("post_rst_valid", token_valid, 0);
        end

        // Randomized mix of entries and frees.
        for (int it = 0; it < 60; it++) begin
            int op;
            int r;
            int d;
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                do_free(3'($urandom_range(0, 7)));
            end else begin
                r = int'($urandom_range(0, 9));
                d = (r < 7) ? int'($urandom_range(0, 5)) : ((r == 7) ? ACK_T - 1 : ACK_T + 3);
                do_entry(3'($urandom), d, 1'b0, 3'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
